// File: rtl/csr_bus_master.sv
// CSR bus initiator: runs one write / read / read-modify-write command at a time
// as single-cycle register strobes and returns the result over a valid/ready response.
module csr_bus_master #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              reg_clk_i,
  input  logic              reg_rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  input  logic [DATA_W-1:0] cmd_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              reg_wr_en_o,
  output logic              reg_rd_en_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [DATA_W-1:0] reg_wr_data_o,
  input  logic [DATA_W-1:0] reg_rd_data_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_WR,
    S_RSP
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RMW   = 2'b10,
    OP_RSVD  = 2'b11
  } op_t;

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                busy_q, busy_d;

  // Next-state and next-output logic; every output is the registered image of
  // the state being entered, so strobes coincide with the RD / WR state cycles.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = rsp_valid_q;
    rd_en_d     = 1'b0;
    wr_en_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = op_t'(cmd_op_i);
          wdata_d = cmd_wdata_i;
          mask_d  = cmd_mask_i;
          unique case (op_t'(cmd_op_i))
            OP_WRITE: begin
              addr_d    = cmd_addr_i;
              wr_data_d = cmd_wdata_i;
              wr_en_d   = 1'b1;
              rdata_d   = '0;
              err_d     = 1'b0;
              state_d   = S_WR;
            end
            OP_READ, OP_RMW: begin
              addr_d  = cmd_addr_i;
              rd_en_d = 1'b1;
              err_d   = 1'b0;
              state_d = S_RD;
            end
            OP_RSVD: begin
              rdata_d     = '0;
              err_d       = 1'b1;
              rsp_valid_d = 1'b1;
              state_d     = S_RSP;
            end
          endcase
        end
      end
      S_RD: begin
        cnt_d   = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          cnt_d   = '0;
          rdata_d = reg_rd_data_i;
          if (op_q == OP_RMW) begin
            wr_data_d = (reg_rd_data_i & ~mask_q) | (wdata_q & mask_q);
            wr_en_d   = 1'b1;
            state_d   = S_WR;
          end else begin
            rsp_valid_d = 1'b1;
            state_d     = S_RSP;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and output registers; reset drops any in-flight command silently.
  always_ff @(posedge reg_clk_i or posedge reg_rst_i) begin
    if (reg_rst_i) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WRITE;
      cnt_q       <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rd_en_q     <= rd_en_d;
      wr_en_q     <= wr_en_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign reg_wr_en_o   = wr_en_q;
  assign reg_rd_en_o   = rd_en_q;
  assign reg_addr_o    = addr_q;
  assign reg_wr_data_o = wr_data_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_csr_bus_master.sv
// Bench for csr_bus_master: two instances (read latency 1 and 3) share one command
// stream; each has its own CSR slave memory. Directed table plus random commands.
module tb_csr_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [31:0] cmd_mask = '0;
  logic        rsp_ready = 1'b1;

  logic        cmd_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic        wr_en     [2];
  logic        rd_en     [2];
  logic        busy      [2];
  logic [31:0] rsp_rdata [2];
  logic [31:0] wdat      [2];
  logic [31:0] rdd       [2];
  logic [7:0]  addr      [2];

  // slave memories and read-return pipelines
  logic [31:0] smem  [2][256];
  logic [31:0] pdata [2];
  int          pcnt  [2] = '{0, 0};
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a = '0;
  logic [31:0] pre_v = '0;

  logic [31:0] mdl [256];
  int tests = 0;
  int failed = 0;
  int viol = 0;
  logic prd [2] = '{1'b0, 1'b0};
  logic pwr [2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  csr_bus_master #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(1)) u_dut1 (
    .reg_clk_i(clk), .reg_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[0]), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]), .reg_wr_en_o(wr_en[0]), .reg_rd_en_o(rd_en[0]),
    .reg_addr_o(addr[0]), .reg_wr_data_o(wdat[0]), .reg_rd_data_i(rdd[0]),
    .busy_o(busy[0])
  );

  csr_bus_master #(.ADDR_W(8), .DATA_W(32), .RD_LATENCY(3)) u_dut3 (
    .reg_clk_i(clk), .reg_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready[1]), .cmd_op_i(cmd_op),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]), .reg_wr_en_o(wr_en[1]), .reg_rd_en_o(rd_en[1]),
    .reg_addr_o(addr[1]), .reg_wr_data_o(wdat[1]), .reg_rd_data_i(rdd[1]),
    .busy_o(busy[1])
  );

  // CSR slave: writes land on the strobe edge; read data is valid only in the
  // cycle exactly RD_LATENCY after the read strobe, garbage otherwise.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pre_en) smem[d][pre_a] <= pre_v;
      else if (wr_en[d]) smem[d][addr[d]] <= wdat[d];
      if (rst) pcnt[d] <= 0;
      else if (rd_en[d]) begin
        pcnt[d]  <= (d == 0) ? 1 : 3;
        pdata[d] <= smem[d][addr[d]];
      end else if (pcnt[d] != 0) pcnt[d] <= pcnt[d] - 1;
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) rdd[d] = (pcnt[d] == 1) ? pdata[d] : ~pdata[d];
  end

  // strobe rules: never both, never two cycles in a row
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        if (rd_en[d] && wr_en[d]) viol++;
        if (rd_en[d] && prd[d]) viol++;
        if (wr_en[d] && pwr[d]) viol++;
        prd[d] = rd_en[d];
        pwr[d] = wr_en[d];
      end else begin
        prd[d] = 1'b0;
        pwr[d] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s lat%0d: got %h expected %h", nm, (d == 0) ? 1 : 3, act, exp);
    end
  endtask

  task automatic preset(input logic [7:0] a, input logic [31:0] v);
    pre_en = 1'b1; pre_a = a; pre_v = v;
    step();
    pre_en = 1'b0;
    mdl[a] = v;
  endtask

  task automatic chk_reset(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_cmd_ready"}, d, {31'b0, cmd_ready[d]}, 32'd1);
      chk({tag, "_rsp_valid"}, d, {31'b0, rsp_valid[d]}, 32'd0);
      chk({tag, "_strobes"}, d, {30'b0, rd_en[d], wr_en[d]}, 32'd0);
      chk({tag, "_busy"}, d, {31'b0, busy[d]}, 32'd0);
      chk({tag, "_addr"}, d, {24'b0, addr[d]}, 32'd0);
      chk({tag, "_wdata"}, d, wdat[d], 32'd0);
      chk({tag, "_rdata"}, d, rsp_rdata[d], 32'd0);
      chk({tag, "_err"}, d, {31'b0, rsp_err[d]}, 32'd0);
    end
  endtask

  // One command through both instances; expected cycle numbers are relative to
  // the accept cycle N (cycle 0).
  task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] mk, input int hold, input logic [31:0] e_rdata,
                         input logic e_err, input logic [31:0] e_wdata);
    int e_rd [2]; int e_wr [2]; int e_rsp [2];
    int rdc [2]; int wrc [2]; int rd_at [2]; int wr_at [2]; int rsp_at [2]; int hs_at [2];
    int stab [2]; logic [31:0] held [2];
    int rel; int mn; int mx; int lat;
    for (int d = 0; d < 2; d++) begin
      lat = (d == 0) ? 1 : 3;
      e_rd[d]  = (op == 2'b01 || op == 2'b10) ? 1 : 0;
      e_wr[d]  = (op == 2'b00) ? 1 : (op == 2'b10) ? lat + 2 : 0;
      e_rsp[d] = (op == 2'b00) ? 2 : (op == 2'b01) ? lat + 2 : (op == 2'b10) ? lat + 3 : 1;
      rdc[d] = 0; wrc[d] = 0; rd_at[d] = -1; wr_at[d] = -1; rsp_at[d] = -1; hs_at[d] = -1;
      stab[d] = 0; held[d] = '0;
      chk("cmd_ready_before_cmd", d, {31'b0, cmd_ready[d]}, 32'd1);
    end
    mn  = (e_rsp[0] < e_rsp[1]) ? e_rsp[0] : e_rsp[1];
    mx  = (e_rsp[0] > e_rsp[1]) ? e_rsp[0] : e_rsp[1];
    rel = (hold > 0) ? mx + hold : 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = wd; cmd_mask = mk;
    rsp_ready = (rel == 0);
    step();
    for (int k = 1; k <= 60; k++) begin
      // junk commands while both instances are certainly busy must be ignored
      cmd_valid = (k < mn);
      cmd_op = 2'($urandom); cmd_addr = 8'($urandom);
      cmd_wdata = $urandom; cmd_mask = $urandom;
      rsp_ready = (k >= rel);
      for (int d = 0; d < 2; d++) begin
        if (rd_en[d]) begin
          rdc[d]++; rd_at[d] = k;
          chk("rd_addr", d, {24'b0, addr[d]}, {24'b0, a});
        end
        if (wr_en[d]) begin
          wrc[d]++; wr_at[d] = k;
          chk("wr_addr", d, {24'b0, addr[d]}, {24'b0, a});
          chk("wr_data", d, wdat[d], e_wdata);
        end
        if (hs_at[d] >= 0) begin
          if (k == hs_at[d] + 1) begin
            chk("cmd_ready_after_rsp", d, {31'b0, cmd_ready[d]}, 32'd1);
            chk("rsp_valid_dropped", d, {31'b0, rsp_valid[d]}, 32'd0);
          end else if (rsp_valid[d]) stab[d]++;
        end else begin
          if (!busy[d] || cmd_ready[d]) stab[d]++;
          if (rsp_valid[d]) begin
            if (rsp_at[d] < 0) begin
              rsp_at[d] = k; held[d] = rsp_rdata[d];
              chk("rsp_rdata", d, rsp_rdata[d], e_rdata);
              chk("rsp_err", d, {31'b0, rsp_err[d]}, {31'b0, e_err});
            end else if (rsp_rdata[d] !== held[d]) stab[d]++;
            if (rsp_ready) hs_at[d] = k;
          end else if (rsp_at[d] >= 0) stab[d]++;
        end
      end
      if (hs_at[0] >= 0 && hs_at[1] >= 0 && k > hs_at[0] && k > hs_at[1]) break;
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rd_strobe_count", d, rdc[d], e_rd[d]);
      chk("wr_strobe_count", d, wrc[d], (e_wr[d] > 0) ? 1 : 0);
      if (e_rd[d] > 0) chk("rd_strobe_cycle", d, rd_at[d], 1);
      if (e_wr[d] > 0) chk("wr_strobe_cycle", d, wr_at[d], e_wr[d]);
      chk("rsp_cycle", d, rsp_at[d], e_rsp[d]);
      chk("rsp_hold_stable", d, stab[d], 0);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [31:0] mk;
    logic [31:0] init;
    int          hold;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl [5];

  initial begin
    logic [1:0]  op;
    logic [7:0]  a;
    logic [31:0] wd, mk, er, ew;
    logic        ee;
    int          cnt;

    tbl[0] = '{2'b00, 8'h00, 32'h0000_80AA, 32'h0, 32'h0, 0, 32'h0, 1'b0, 32'h0000_80AA};
    tbl[1] = '{2'b01, 8'h01, 32'h0, 32'h0, 32'h0000_0015, 0, 32'h0000_0015, 1'b0, 32'h0};
    tbl[2] = '{2'b10, 8'h00, 32'h12, 32'hFF, 32'h0000_8005, 0, 32'h0000_8005, 1'b0, 32'h0000_8012};
    tbl[3] = '{2'b01, 8'h01, 32'h0, 32'h0, 32'h0000_0015, 5, 32'h0000_0015, 1'b0, 32'h0};
    tbl[4] = '{2'b11, 8'h22, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 0, 32'h0, 1'b1, 32'h0};

    #1 rst = 1'b1;
    #1 chk_reset("reset");
    step();
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 16; i++) preset(8'(i), $urandom);

    for (int i = 0; i < 5; i++) begin
      preset(tbl[i].a, tbl[i].init);
      run_txn(tbl[i].op, tbl[i].a, tbl[i].wd, tbl[i].mk, tbl[i].hold,
              tbl[i].e_rdata, tbl[i].e_err, tbl[i].e_wdata);
      if (tbl[i].op == 2'b00 || tbl[i].op == 2'b10) mdl[tbl[i].a] = tbl[i].e_wdata;
    end

    // random commands against the memory model
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); a = 8'($urandom_range(0, 15));
      wd = $urandom; mk = $urandom;
      er = 32'h0; ee = 1'b0; ew = 32'h0;
      case (op)
        2'b00: begin ew = wd; mdl[a] = wd; end
        2'b01: er = mdl[a];
        2'b10: begin er = mdl[a]; ew = (mdl[a] & ~mk) | (wd & mk); mdl[a] = ew; end
        default: ee = 1'b1;
      endcase
      run_txn(op, a, wd, mk, int'($urandom_range(0, 3)), er, ee, ew);
    end

    // reset while the latency-3 instance waits for read data
    preset(8'h05, 32'hCAFE_0005);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h05; rsp_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    chk("pre_reset_rsp_valid", 0, {31'b0, rsp_valid[0]}, 32'd1);
    chk("pre_reset_busy", 1, {31'b0, busy[1]}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset("midop_reset");
    step();
    rst = 1'b0;
    rsp_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      for (int d = 0; d < 2; d++) if (rsp_valid[d] || rd_en[d] || wr_en[d] || busy[d]) cnt++;
    end
    chk("no_activity_after_reset", 0, cnt, 0);
    run_txn(2'b00, 8'h05, 32'h1234_5678, 32'h0, 0, 32'h0, 1'b0, 32'h1234_5678);
    mdl[8'h05] = 32'h1234_5678;
    run_txn(2'b01, 8'h05, 32'h0, 32'h0, 0, mdl[8'h05], 1'b0, 32'h0);

    step();
    chk("strobe_protocol_violations", 0, viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule
